// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - single-lane MAC sequencer computing C = A x B for square matrices
// Optional MATMUL_SEQ_PERF_EN adds perf_cycles, a saturating count of busy cycles per command.
module matmul_seq_ctrl #(
  parameter int N    = 5,
  parameter int DW   = 8,
  parameter int ACCW = 19,
  localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [IW-1:0]   dim,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            a_rd_en,
  output logic [IW-1:0]   a_rd_row,
  output logic [IW-1:0]   a_rd_col,
  input  logic [DW-1:0]   a_rd_data,
  output logic            b_rd_en,
  output logic [IW-1:0]   b_rd_row,
  output logic [IW-1:0]   b_rd_col,
  input  logic [DW-1:0]   b_rd_data,
  output logic            c_wr_en,
  output logic [IW-1:0]   c_wr_row,
  output logic [IW-1:0]   c_wr_col,
`ifdef MATMUL_SEQ_PERF_EN
  output logic [15:0]     perf_cycles,
`endif
  output logic [ACCW-1:0] c_wr_data
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

  localparam logic [IW:0] NMAX = (IW+1)'(N);

  state_t          state_q, state_d;
  logic [IW-1:0]   dim_q, dim_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            err_q, err_d;
  logic [2*DW-1:0] prod;
  logic            dim_ok, accept;
  logic            last_i, last_j, last_k;

  assign prod   = {{DW{1'b0}}, a_rd_data} * {{DW{1'b0}}, b_rd_data};
  assign dim_ok = (dim != '0) && ({1'b0, dim} <= NMAX);
  assign accept = (state_q == S_IDLE) && start && dim_ok;
  assign last_i = (i_q == dim_q - IW'(1));
  assign last_j = (j_q == dim_q - IW'(1));
  assign last_k = (k_q == dim_q - IW'(1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      dim_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dim_q   <= dim_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dim_d   = dim_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (dim_ok) begin
            dim_d   = dim;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            err_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // Data on the read ports belongs to the previous k, so k=0 only clears.
        if (k_q == '0) acc_d = '0;
        else           acc_d = acc_q + ACCW'(prod);
        if (last_k) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + IW'(1);
        end
      end
      S_DRAIN: begin
        acc_d   = acc_q + ACCW'(prod);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = S_RUN;
        if (last_j) begin
          j_d = '0;
          if (last_i) begin
            i_d     = '0;
            state_d = S_DONE;
          end else begin
            i_d = i_q + IW'(1);
          end
        end else begin
          j_d = j_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The WRITE strobe is Moore-decoded, so an abort there still completes the write.
    if (abort && (state_q == S_RUN || state_q == S_DRAIN || state_q == S_WRITE))
      state_d = S_IDLE;
  end

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_q;
  assign a_rd_en   = (state_q == S_RUN);
  assign b_rd_en   = (state_q == S_RUN);
  assign a_rd_row  = i_q;
  assign a_rd_col  = k_q;
  assign b_rd_row  = k_q;
  assign b_rd_col  = j_q;
  assign c_wr_en   = (state_q == S_WRITE);
  assign c_wr_row  = i_q;
  assign c_wr_col  = j_q;
  assign c_wr_data = acc_q;

`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept)                          perf_d = '0;
    else if (busy && perf_q != 16'hFFFF) perf_d = perf_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - directed bench with a cycle-offset model of matmul_seq_ctrl
module tb_matmul_seq_ctrl;
  localparam int N    = 5;
  localparam int DW   = 8;
  localparam int ACCW = 19;
  localparam int IW   = 3;

  logic            clk = 1'b0;
  logic            resetn, start, abort;
  logic [IW-1:0]   dim;
  logic            busy, done, err, a_rd_en, b_rd_en, c_wr_en;
  logic [IW-1:0]   a_rd_row, a_rd_col, b_rd_row, b_rd_col, c_wr_row, c_wr_col;
  logic [DW-1:0]   a_rd_data, b_rd_data;
  logic [ACCW-1:0] c_wr_data;
`ifdef MATMUL_SEQ_PERF_EN
  logic [15:0]     perf_cycles;
`endif

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int mat_a[8][8], mat_b[8][8];
  int m_mode = 0, m_t0 = 0, m_dim = 0, m_stop = -1;
  bit chk_en = 1'b0;
  int last_done_n = -1, last_err = 0;
  int wr_n[$], wr_row[$], wr_col[$], wr_data[$];

  matmul_seq_ctrl #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .dim(dim), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .a_rd_en(a_rd_en), .a_rd_row(a_rd_row), .a_rd_col(a_rd_col), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_row(b_rd_row), .b_rd_col(b_rd_col), .b_rd_data(b_rd_data),
    .c_wr_en(c_wr_en), .c_wr_row(c_wr_row), .c_wr_col(c_wr_col),
`ifdef MATMUL_SEQ_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .c_wr_data(c_wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories answer one cycle after a strobe and return garbage otherwise.
  always @(posedge clk) begin
    a_rd_data <= a_rd_en ? DW'(mat_a[a_rd_row][a_rd_col]) : DW'($urandom);
    b_rd_data <= b_rd_en ? DW'(mat_b[b_rd_row][b_rd_col]) : DW'($urandom);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cval(input int i, input int j, input int d);
    int s = 0;
    for (int k = 0; k < d; k++) s += mat_a[i][k] * mat_b[k][j];
    return s;
  endfunction

  // Element e of a command occupies cycles e*(d+2)+1 .. e*(d+2)+d+2: d reads, drain, write.
  always @(negedge clk) begin : cmp
    int n, per, last, el, p, ei, ej, ek;
    logic e_busy, e_done, e_err, e_rd, e_wr;
    if (chk_en) begin
      e_busy = 0; e_done = 0; e_err = 0; e_rd = 0; e_wr = 0;
      ei = 0; ej = 0; ek = 0;
      n = cyc - m_t0;
      if (m_mode == 1 && n >= 1 && (m_stop < 0 || cyc <= m_stop)) begin
        per  = m_dim + 2;
        last = m_dim * m_dim * per;
        if (n <= last) begin
          e_busy = 1;
          el = (n - 1) / per;
          p  = (n - 1) % per;
          ei = el / m_dim;
          ej = el % m_dim;
          if (p < m_dim) begin
            e_rd = 1;
            ek = p;
          end else if (p == m_dim + 1) begin
            e_wr = 1;
          end
        end else if (n == last + 1) begin
          e_done = 1;
        end
      end else if (m_mode == 2 && n == 1) begin
        e_done = 1;
        e_err  = 1;
      end
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("a_rd_en", a_rd_en, e_rd);
      check("b_rd_en", b_rd_en, e_rd);
      check("c_wr_en", c_wr_en, e_wr);
      if (e_done) check("err", err, e_err);
      if (e_rd) begin
        check("a_rd_row", a_rd_row, ei);
        check("a_rd_col", a_rd_col, ek);
        check("b_rd_row", b_rd_row, ek);
        check("b_rd_col", b_rd_col, ej);
      end
      if (e_wr) begin
        check("c_wr_row", c_wr_row, ei);
        check("c_wr_col", c_wr_col, ej);
        check("c_wr_data", c_wr_data, cval(ei, ej, m_dim));
      end
      if (c_wr_en === 1'b1) begin
        wr_n.push_back(n);
        wr_row.push_back(int'(c_wr_row));
        wr_col.push_back(int'(c_wr_col));
        wr_data.push_back(int'(c_wr_data));
      end
      if (done === 1'b1) begin
        last_done_n = n;
        last_err    = int'(err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d);
    start = 1'b1;
    dim   = IW'(d);
    m_t0  = cyc;
    m_dim = d;
    m_mode = (d >= 1 && d <= N) ? 1 : 2;
    m_stop = -1;
    last_done_n = -1;
    wr_n.delete(); wr_row.delete(); wr_col.delete(); wr_data.delete();
    tick();
    start = 1'b0;
    dim   = IW'(7);
  endtask

  task automatic load_small();
    mat_a[0][0] = 1; mat_a[0][1] = 2; mat_a[1][0] = 3; mat_a[1][1] = 4;
    mat_b[0][0] = 1; mat_b[0][1] = 2; mat_b[1][0] = 3; mat_b[1][1] = 4;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; dim = '0;
    repeat (3) tick();
    resetn = 1'b1;
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_c_wr_data", c_wr_data, 0);
    check("rst_a_rd_row", a_rd_row, 0);
    check("rst_c_wr_col", c_wr_col, 0);

    // Identity times B(r,c)=5r+c
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        mat_a[r][c] = (r == c) ? 1 : 0;
        mat_b[r][c] = 5 * r + c;
      end
    issue(5);
    repeat (180) tick();
    check("t1_nwr", wr_n.size(), 25);
    if (wr_n.size() == 25)
      for (int e = 0; e < 25; e++) begin
        check("t1_wr_cycle", wr_n[e], 7 * e + 7);
        check("t1_wr_row", wr_row[e], e / 5);
        check("t1_wr_col", wr_col[e], e % 5);
        check("t1_wr_data", wr_data[e], e);
      end
    check("t1_done_cycle", last_done_n, 176);
    check("t1_err", last_err, 0);
`ifdef MATMUL_SEQ_PERF_EN
    check("t1_perf", perf_cycles, 175);
`endif

    // All 0xFF: widest possible sum
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        mat_a[r][c] = 255;
        mat_b[r][c] = 255;
      end
    issue(5);
    repeat (180) tick();
    check("t2_nwr", wr_n.size(), 25);
    foreach (wr_data[e]) check("t2_wr_data", wr_data[e], 325125);

    // dim=1
    mat_a[0][0] = 3; mat_b[0][0] = 7;
    issue(1);
    repeat (6) tick();
    check("t3_nwr", wr_n.size(), 1);
    if (wr_n.size() == 1) begin
      check("t3_wr_cycle", wr_n[0], 3);
      check("t3_wr_data", wr_data[0], 21);
    end
    check("t3_done_cycle", last_done_n, 4);

    // Rejected sizes
    issue(0);
    repeat (3) tick();
    check("t4a_done_cycle", last_done_n, 1);
    check("t4a_err", last_err, 1);
    check("t4a_nwr", wr_n.size(), 0);
    issue(6);
    repeat (3) tick();
    check("t4b_done_cycle", last_done_n, 1);
    check("t4b_err", last_err, 1);
    check("t4b_nwr", wr_n.size(), 0);

    // Start during busy is ignored; abort during element (1,2) RUN
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        mat_a[r][c] = r + c + 1;
        mat_b[r][c] = 2 * r + c + 1;
      end
    issue(3);
    repeat (4) tick();
    start = 1'b1; dim = IW'(2);
    tick();
    start = 1'b0;
    repeat (21) tick();
    abort  = 1'b1;
    m_stop = cyc;
    tick();
    abort = 1'b0;
    repeat (5) tick();
    check("t5_nwr", wr_n.size(), 5);
    if (wr_n.size() > 0) check("t5_wr0_data", wr_data[0], 22);
    check("t5_no_done", last_done_n, -1);
    load_small();
    issue(2);
    repeat (20) tick();
    check("t5_next_done_cycle", last_done_n, 17);
    check("t5_next_nwr", wr_n.size(), 4);

    // Reset during the first WRITE, then a clean dim=2 command
    load_small();
    issue(2);
    repeat (3) tick();
    resetn = 1'b0;
    m_stop = cyc;
    tick();
    resetn = 1'b1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_c_wr_en", c_wr_en, 0);
    check("t6_rst_c_wr_data", c_wr_data, 0);
    check("t6_rst_c_wr_row", c_wr_row, 0);
`ifdef MATMUL_SEQ_PERF_EN
    check("t6_rst_perf", perf_cycles, 0);
`endif
    issue(2);
    repeat (20) tick();
    check("t6_nwr", wr_n.size(), 4);
    if (wr_n.size() == 4) begin
      check("t6_wr0", wr_data[0], 7);
      check("t6_wr1", wr_data[1], 10);
      check("t6_wr2", wr_data[2], 15);
      check("t6_wr3", wr_data[3], 22);
    end
    check("t6_done_cycle", last_done_n, 17);
`ifdef MATMUL_SEQ_PERF_EN
    check("t6_perf", perf_cycles, 16);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
